// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: shared definitions for the branch redirect controller.
// Holds the EX branch-type codes, the controller state encoding and the JALR
// target alignment helper.
package branch_redirect_ctrl_pkg;

  // Branch type codes carried by ex_br_type.
  localparam logic [2:0] NOBRANCH = 3'd0;
  localparam logic [2:0] BEQ      = 3'd1;
  localparam logic [2:0] BNE      = 3'd2;
  localparam logic [2:0] BLT      = 3'd3;
  localparam logic [2:0] BLTU     = 3'd4;
  localparam logic [2:0] BGE      = 3'd5;
  localparam logic [2:0] BGEU     = 3'd6;

  // Controller states.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  // JALR targets always have bit 0 forced to zero.
  function automatic logic [31:0] jalr_align(input logic [31:0] target);
    return {target[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/br_stat_counter.sv
// br_stat_counter: 32-bit saturating event counter with increment enable.
// Holds at 0xFFFF_FFFF instead of wrapping; synchronous active-high clear.
module br_stat_counter
  import branch_redirect_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_r;

  // Count enabled events, sticking at the all-ones value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 32'h0000_0000;
    end else if (inc && (count_r != 32'hFFFF_FFFF)) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: selects the oldest control-flow redirect (EX branch or
// JALR over ID JAL), drives PC-select and pipeline flushes, and holds a
// redirect pending while fetch is busy with an instruction-memory miss.
// Optional statistics counters are built when BR_STATS_EN is defined;
// otherwise the counter ports read as zero.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ex_br_type,
  input  logic        ex_br,
  input  logic        ex_jalr,
  input  logic [31:0] ex_target,
  input  logic        id_jal,
  input  logic [31:0] id_jal_target,
  input  logic        fetch_ready,
  input  logic        mem_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        stall_if,
  output logic [31:0] cnt_branch,
  output logic [31:0] cnt_taken,
  output logic [31:0] cnt_pend_cycles
);

  state_e      state_r;
  state_e      state_nx_s;
  logic [31:0] pend_pc_r;
  logic [31:0] pend_pc_nx_s;
  logic        ex_redir_s;
  logic [31:0] ex_tgt_s;

  // Decode the EX-stage redirect request and its (aligned) target.
  always_comb begin
    ex_redir_s = ex_jalr | ((ex_br_type != NOBRANCH) & ex_br);
    if (ex_jalr) begin
      ex_tgt_s = jalr_align(ex_target);
    end else begin
      ex_tgt_s = ex_target;
    end
  end

  // Output and next-state logic: IDLE paths are combinational from inputs,
  // PEND outputs depend only on the held target and fetch_ready.
  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    stall_if       = 1'b0;
    state_nx_s     = state_r;
    pend_pc_nx_s   = pend_pc_r;
    case (state_r)
      IDLE: begin
        if (mem_stall) begin
          // Pipeline frozen: requests will be re-presented next cycle.
          state_nx_s = IDLE;
        end else if (ex_redir_s) begin
          // EX is older; a same-cycle ID JAL is wrong-path and dropped.
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (fetch_ready) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_tgt_s;
          end else begin
            stall_if     = 1'b1;
            state_nx_s   = PEND;
            pend_pc_nx_s = ex_tgt_s;
          end
        end else if (id_jal) begin
          flush_ifid = 1'b1;
          if (fetch_ready) begin
            redirect_valid = 1'b1;
            redirect_pc    = id_jal_target;
          end else begin
            stall_if     = 1'b1;
            state_nx_s   = PEND;
            pend_pc_nx_s = id_jal_target;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      PEND: begin
        // New requests here come from the wrong path and are ignored.
        flush_ifid     = 1'b1;
        stall_if       = 1'b1;
        redirect_pc    = pend_pc_r;
        redirect_valid = fetch_ready;
        if (fetch_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = PEND;
        end
      end
      default: begin
        state_nx_s   = IDLE;
        pend_pc_nx_s = 32'h0000_0000;
      end
    endcase
  end

  // State and pending-target registers; reset discards any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pend_pc_r <= 32'h0000_0000;
    end else begin
      state_r   <= state_nx_s;
      pend_pc_r <= pend_pc_nx_s;
    end
  end

`ifdef BR_STATS_EN
  logic br_inc_s;
  logic taken_inc_s;
  logic pend_inc_s;

  // Counter enables: branches seen while unstalled in IDLE, and PEND cycles.
  always_comb begin
    br_inc_s    = (state_r == IDLE) & ~mem_stall & (ex_br_type != NOBRANCH);
    taken_inc_s = br_inc_s & ex_br;
    pend_inc_s  = (state_r == PEND);
  end

  br_stat_counter u_cnt_branch (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_inc_s),
    .count (cnt_branch)
  );

  br_stat_counter u_cnt_taken (
    .clk   (clk),
    .rst   (rst),
    .inc   (taken_inc_s),
    .count (cnt_taken)
  );

  br_stat_counter u_cnt_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (pend_inc_s),
    .count (cnt_pend_cycles)
  );
`else
  assign cnt_branch      = 32'h0000_0000;
  assign cnt_taken       = 32'h0000_0000;
  assign cnt_pend_cycles = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed scoreboard bench for branch_redirect_ctrl.
// Statistics-counter checks are compiled in when BR_STATS_EN is defined.
module tb_branch_redirect_ctrl;
  import branch_redirect_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  ex_br_type;
  logic        ex_br;
  logic        ex_jalr;
  logic [31:0] ex_target;
  logic        id_jal;
  logic [31:0] id_jal_target;
  logic        fetch_ready;
  logic        mem_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic        stall_if;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_taken;
  logic [31:0] cnt_pend_cycles;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] pc;
    logic        chk_pc;
    logic        fi;
    logic        fx;
    logic        st;
  } exp_t;

  exp_t sb[$];

  branch_redirect_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ex_br_type      (ex_br_type),
    .ex_br           (ex_br),
    .ex_jalr         (ex_jalr),
    .ex_target       (ex_target),
    .id_jal          (id_jal),
    .id_jal_target   (id_jal_target),
    .fetch_ready     (fetch_ready),
    .mem_stall       (mem_stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .stall_if        (stall_if),
    .cnt_branch      (cnt_branch),
    .cnt_taken       (cnt_taken),
    .cnt_pend_cycles (cnt_pend_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Drive one cycle of inputs at the falling edge.
  task automatic drive(input logic [2:0] bt, input logic br, input logic jalr,
                       input logic [31:0] et, input logic jal, input logic [31:0] jt,
                       input logic fr, input logic ms);
    @(negedge clk);
    ex_br_type    = bt;
    ex_br         = br;
    ex_jalr       = jalr;
    ex_target     = et;
    id_jal        = jal;
    id_jal_target = jt;
    fetch_ready   = fr;
    mem_stall     = ms;
  endtask

  // Drive a cycle, push its expectation, then pop and compare mid-cycle.
  task automatic step(input string tag, input logic [2:0] bt, input logic br,
                      input logic jalr, input logic [31:0] et, input logic jal,
                      input logic [31:0] jt, input logic fr, input logic ms,
                      input logic ev, input logic [31:0] epc, input logic ecp,
                      input logic efi, input logic efx, input logic est);
    exp_t e;
    exp_t g;
    drive(bt, br, jalr, et, jal, jt, fr, ms);
    e.tag = tag; e.v = ev; e.pc = epc; e.chk_pc = ecp;
    e.fi = efi; e.fx = efx; e.st = est;
    sb.push_back(e);
    #2;
    g = sb.pop_front();
    chk({g.tag, ".valid"}, {31'd0, redirect_valid}, {31'd0, g.v});
    if (g.chk_pc) chk({g.tag, ".pc"}, redirect_pc, g.pc);
    chk({g.tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, g.fi});
    chk({g.tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, g.fx});
    chk({g.tag, ".stall_if"}, {31'd0, stall_if}, {31'd0, g.st});
  endtask

  initial begin
    rst = 1'b1;
    ex_br_type = NOBRANCH; ex_br = 1'b0; ex_jalr = 1'b0; ex_target = 32'h0;
    id_jal = 1'b0; id_jal_target = 32'h0; fetch_ready = 1'b1; mem_stall = 1'b0;
    drive(NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    step("reset", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt_branch", cnt_branch, 32'h0);
    chk("reset.cnt_taken", cnt_taken, 32'h0);
    chk("reset.cnt_pend", cnt_pend_cycles, 32'h0);
    rst = 1'b0;

    // Idle and a not-taken branch produce nothing.
    step("idle", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("beq_nt", BEQ, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Taken BEQ, direct redirect.
    step("beq_t", BEQ, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
    // Odd JALR target with fetch ready: bit 0 cleared.
    step("jalr_rdy", NOBRANCH, 1'b0, 1'b1, 32'h0000_1235, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b1, 32'h0000_1234, 1'b1, 1'b1, 1'b1, 1'b0);

    // JALR during I-miss: capture, three PEND waits, then delivery.
    step("jalr_cap", NOBRANCH, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0, 1'b0,
         1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("pend1", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
         1'b0, 32'h202, 1'b1, 1'b1, 1'b0, 1'b1);
    step("pend2_wrongpath", BNE, 1'b1, 1'b0, 32'h999, 1'b1, 32'h888, 1'b0, 1'b0,
         1'b0, 32'h202, 1'b1, 1'b1, 1'b0, 1'b1);
    step("pend3_memstall", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1,
         1'b0, 32'h202, 1'b1, 1'b1, 1'b0, 1'b1);
    step("pend_deliver", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b1, 32'h202, 1'b1, 1'b1, 1'b0, 1'b1);
    step("after_pend", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // EX wins over simultaneous ID JAL; the JAL is dropped.
    step("bne_vs_jal", BNE, 1'b1, 1'b0, 32'h400, 1'b1, 32'h800, 1'b1, 1'b0,
         1'b1, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0);
    step("jal_dropped", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // JAL under memory stall is held off, then taken.
    step("jal_ms1", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("jal_ms2", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("jal_go", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0,
         1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset during PEND discards the pending redirect.
    step("jal_cap", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0C00, 1'b0, 1'b0,
         1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("jal_pend", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
         1'b0, 32'h0000_0C00, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef BR_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // Five BLT cycles: two taken, one of those under mem_stall.
    step("blt1_t", BLT, 1'b1, 1'b0, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 1'b0);
    step("blt2_nt", BLT, 1'b0, 1'b0, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("blt3_t_ms", BLT, 1'b1, 1'b0, 32'h500, 1'b0, 32'h0, 1'b1, 1'b1,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("blt4_nt", BLT, 1'b0, 1'b0, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("blt5_nt", BLT, 1'b0, 1'b0, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    chk("stats.cnt_branch", cnt_branch, 32'd4);
    chk("stats.cnt_taken", cnt_taken, 32'd1);
    chk("stats.cnt_pend0", cnt_pend_cycles, 32'd0);

    // Two PEND cycles.
    step("st_cap", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 1'b0,
         1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("st_p1", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
         1'b0, 32'h60, 1'b1, 1'b1, 1'b0, 1'b1);
    step("st_p2", NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
         1'b1, 32'h60, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    chk("stats.cnt_pend2", cnt_pend_cycles, 32'd2);

    // Saturation from preloaded values.
    force dut.u_cnt_branch.count_r = 32'hFFFF_FFFE;
    force dut.u_cnt_taken.count_r  = 32'hFFFF_FFFF;
    #1;
    release dut.u_cnt_branch.count_r;
    release dut.u_cnt_taken.count_r;
    drive(BLT, 1'b1, 1'b0, 32'h700, 1'b0, 32'h0, 1'b1, 1'b0);
    drive(BLT, 1'b1, 1'b0, 32'h700, 1'b0, 32'h0, 1'b1, 1'b0);
    drive(BLT, 1'b1, 1'b0, 32'h700, 1'b0, 32'h0, 1'b1, 1'b0);
    drive(NOBRANCH, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    chk("sat.cnt_branch", cnt_branch, 32'hFFFF_FFFF);
    chk("sat.cnt_taken", cnt_taken, 32'hFFFF_FFFF);
`else
    // Without statistics the counter ports stay at zero after activity.
    chk("nostats.cnt_branch", cnt_branch, 32'h0);
    chk("nostats.cnt_taken", cnt_taken, 32'h0);
    chk("nostats.cnt_pend", cnt_pend_cycles, 32'h0);
`endif

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
